// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, status flag bit positions, FSM encodings.
// Imported by the ALU, the decoder and the status register.
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_SR   = 3'd5;
  localparam logic [2:0] OP_SL   = 3'd6;
  localparam logic [2:0] OP_PASS = 3'd7;

  localparam int NEG   = 3;
  localparam int OVF   = 2;
  localparam int ZERO  = 1;
  localparam int CARRY = 0;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DEC  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of add or subtract with decimal adjust.
// Non-decimal inputs still give a fixed, deterministic digit.
module bcd_digit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       carry_in,
  input  logic       sub,
  output logic [3:0] digit,
  output logic       carry_out
);

  logic [4:0] s;
  logic [5:0] d;

  always_comb begin
    s = {1'b0, a} + {1'b0, b} + {4'b0, carry_in};
    // 6-bit signed difference; bit 5 set means a borrow
    d = {2'b0, a} - {2'b0, b} - {5'b0, ~carry_in};
    digit     = s[3:0];
    carry_out = 1'b0;
    if (sub) begin
      carry_out = ~d[5];
      digit     = d[5] ? d[3:0] - 4'd6 : d[3:0];
    end else if (s > 5'd9) begin
      digit     = s[3:0] + 4'd6;
      carry_out = 1'b1;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked 6502-style ALU: binary ops in one cycle,
// BCD add/sub one digit per cycle through a shared bcd_digit.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter bit BCD_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             bcd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [3:0]       flags,
  output logic [3:0]       flag_we
);

  localparam int ND = WIDTH / 4;
  localparam int KW = (ND > 1) ? $clog2(ND) : 1;
  localparam int M  = WIDTH - 1;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_r, b_r;
  logic             c_r, sub_r, v_r;
  logic [KW-1:0]    k;

  logic [WIDTH-1:0] bo, y_bin, y_dec;
  logic [WIDTH:0]   sum;
  logic [3:0]       f_bin, we_bin;
  logic             go_dec, k_last;
  logic [3:0]       dig;
  logic             dcout;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_comb begin
    bo     = (op == OP_SUB) ? ~b : b;
    sum    = {1'b0, a} + {1'b0, bo} + {{WIDTH{1'b0}}, carry_in};
    y_bin  = a;
    f_bin  = 4'b0;
    we_bin = 4'b1010;
    unique case (1'b1)
      (op == OP_ADD), (op == OP_SUB): begin
        y_bin        = sum[M:0];
        f_bin[CARRY] = sum[WIDTH];
        f_bin[OVF]   = (a[M] == bo[M]) && (sum[M] != a[M]);
        we_bin       = 4'b1111;
      end
      (op == OP_AND): y_bin = a & b;
      (op == OP_OR):  y_bin = a | b;
      (op == OP_XOR): y_bin = a ^ b;
      (op == OP_SR): begin
        y_bin        = {carry_in, a[M:1]};
        f_bin[CARRY] = a[0];
        we_bin       = 4'b1011;
      end
      (op == OP_SL): begin
        y_bin        = {a[M-1:0], carry_in};
        f_bin[CARRY] = a[M];
        we_bin       = 4'b1011;
      end
      default: y_bin = a;
    endcase
    f_bin[NEG]  = y_bin[M];
    f_bin[ZERO] = (y_bin == '0);
  end

  assign go_dec = BCD_EN && bcd && ((op == OP_ADD) || (op == OP_SUB));
  assign k_last = (k == KW'(ND - 1));

  bcd_digit u_digit (
    .a         (a_r[3:0]),
    .b         (b_r[3:0]),
    .carry_in  (c_r),
    .sub       (sub_r),
    .digit     (dig),
    .carry_out (dcout)
  );

  // digits shift in from the top, so y is complete after the last one
  assign y_dec = (y >> 4) | (WIDTH'(dig) << (WIDTH - 4));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      y       <= '0;
      flags   <= 4'b0;
      flag_we <= 4'b0;
      a_r     <= '0;
      b_r     <= '0;
      c_r     <= 1'b0;
      sub_r   <= 1'b0;
      v_r     <= 1'b0;
      k       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (go_dec) begin
              a_r   <= a;
              b_r   <= b;
              c_r   <= carry_in;
              sub_r <= (op == OP_SUB);
              v_r   <= f_bin[OVF];
              k     <= '0;
              state <= DEC;
            end else begin
              y       <= y_bin;
              flags   <= f_bin;
              flag_we <= we_bin;
              state   <= DONE;
            end
          end
        end
        DEC: begin
          a_r <= a_r >> 4;
          b_r <= b_r >> 4;
          c_r <= dcout;
          y   <= y_dec;
          k   <= k + KW'(1);
          if (k_last) begin
            flags   <= {y_dec[M], v_r, (y_dec == '0), dcout};
            flag_we <= 4'b1111;
            state   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Randomised self-checking bench for alu_seq at WIDTH=8 and WIDTH=16
// against a digit-level arithmetic reference model.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        iv8, iv16;
  logic        rdy8, rdy16;
  logic [2:0]  op;
  logic [15:0] a, b;
  logic        carry_in, bcd, out_ready;
  logic        ov8, ov16;
  logic [7:0]  y8;
  logic [15:0] y16;
  logic [3:0]  fl8, fl16, we8, we16;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(8), .BCD_EN(1'b1)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(rdy8),
    .op(op), .a(a[7:0]), .b(b[7:0]), .carry_in(carry_in),
    .bcd(bcd), .out_valid(ov8), .out_ready(out_ready),
    .y(y8), .flags(fl8), .flag_we(we8)
  );

  alu_seq #(.WIDTH(16), .BCD_EN(1'b1)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(rdy16),
    .op(op), .a(a), .b(b), .carry_in(carry_in),
    .bcd(bcd), .out_valid(ov16), .out_ready(out_ready),
    .y(y16), .flags(fl16), .flag_we(we16)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic int obs_y(input int w);
    return (w == 8) ? int'(y8) : int'(y16);
  endfunction
  function automatic int obs_f(input int w);
    return (w == 8) ? int'(fl8) : int'(fl16);
  endfunction
  function automatic int obs_we(input int w);
    return (w == 8) ? int'(we8) : int'(we16);
  endfunction
  function automatic int obs_ov(input int w);
    return (w == 8) ? int'(ov8) : int'(ov16);
  endfunction
  function automatic int obs_rdy(input int w);
    return (w == 8) ? int'(rdy8) : int'(rdy16);
  endfunction

  function automatic int sgn(input int v, input int w);
    return (v >= (1 << (w - 1))) ? v - (1 << w) : v;
  endfunction

  // reference: y, {N,V,Z,C}, write mask and valid latency
  function automatic void model(
    input int w, input int o, input int av, input int bv,
    input int c, input int d,
    output int y, output int f, output int we, output int lat);
    int mask, half, bo, s, r, v, cy, cc, ad, bd, dg;
    mask = (1 << w) - 1;
    half = 1 << (w - 1);
    v = 0; cy = 0; we = 10; lat = 1;
    case (o)
      0, 1: begin
        bo = (o == 1) ? (~bv) & mask : bv;
        s  = av + bo + c;
        r  = sgn(av, w) + sgn(bo, w) + c;
        v  = (r >= half || r < -half) ? 1 : 0;
        y  = s & mask;
        cy = (s >> w) & 1;
        we = 15;
        if (d != 0) begin
          cc = c;
          y  = 0;
          for (int i = 0; i < w / 4; i++) begin
            ad = (av >> (4 * i)) & 15;
            bd = (bv >> (4 * i)) & 15;
            if (o == 0) begin
              dg = ad + bd + cc;
              if (dg > 9) begin dg = dg + 6; cc = 1; end
              else cc = 0;
            end else begin
              dg = ad - bd - (1 - cc);
              if (dg < 0) begin dg = dg - 6; cc = 0; end
              else cc = 1;
            end
            y = y | ((dg & 15) << (4 * i));
          end
          cy  = cc;
          lat = 1 + w / 4;
        end
      end
      2: y = av & bv;
      3: y = av | bv;
      4: y = av ^ bv;
      5: begin
        y  = (c << (w - 1)) | (av >> 1);
        cy = av & 1;
        we = 11;
      end
      6: begin
        y  = ((av << 1) | c) & mask;
        cy = (av >> (w - 1)) & 1;
        we = 11;
      end
      default: y = av;
    endcase
    f = (((y >> (w - 1)) & 1) << 3) | (v << 2)
      | ((y == 0 ? 1 : 0) << 1) | cy;
  endfunction

  task automatic do_op(input int w, input int o, input int av,
                       input int bv, input int c, input int d,
                       input int hold);
    int ey, ef, ewe, elat, lat, hy, hf;
    model(w, o, av, bv, c, d, ey, ef, ewe, elat);
    @(negedge clk);
    op = 3'(o); a = 16'(av); b = 16'(bv);
    carry_in = c[0]; bcd = d[0];
    chk("in_ready_idle", obs_rdy(w), 1);
    if (w == 8) iv8 = 1'b1; else iv16 = 1'b1;
    @(posedge clk);
    #1;
    iv8 = 1'b0; iv16 = 1'b0;
    lat = 1;
    while (obs_ov(w) == 0 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", lat, elat);
    chk("y", obs_y(w), ey);
    chk("flags", obs_f(w), ef);
    chk("flag_we", obs_we(w), ewe);
    chk("in_ready_busy", obs_rdy(w), 0);
    hy = obs_y(w);
    hf = obs_f(w);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", obs_ov(w), 1);
      chk("hold_y", obs_y(w), hy);
      chk("hold_flags", obs_f(w), hf);
      chk("hold_rdy", obs_rdy(w), 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("release_valid", obs_ov(w), 0);
    chk("release_rdy", obs_rdy(w), 1);
  endtask

  initial begin
    rst = 1'b1; iv8 = 1'b0; iv16 = 1'b0; op = 3'd0;
    a = '0; b = '0; carry_in = 1'b0; bcd = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_y8", int'(y8), 0);
    chk("rst_f8", int'(fl8), 0);
    chk("rst_we8", int'(we8), 0);
    chk("rst_ov8", int'(ov8), 0);
    chk("rst_rdy8", int'(rdy8), 1);
    chk("rst_y16", int'(y16), 0);
    chk("rst_rdy16", int'(rdy16), 1);

    do_op(8, 0, 'h7F, 'h01, 0, 0, 0);
    do_op(8, 1, 'h00, 'h01, 1, 0, 0);
    do_op(8, 0, 'h58, 'h46, 1, 1, 0);
    do_op(8, 1, 'h12, 'h21, 1, 1, 0);
    do_op(8, 2, 'hF0, 'h0F, 0, 0, 0);
    do_op(8, 5, 'h01, 'h00, 1, 0, 5);
    do_op(8, 6, 'h81, 'h00, 0, 0, 0);
    do_op(16, 0, 'h9999, 'h0001, 0, 1, 2);

    // reset while the BCD sequence is mid-flight
    @(negedge clk);
    op = 3'd0; a = 16'h0058; b = 16'h0046;
    carry_in = 1'b1; bcd = 1'b1; iv8 = 1'b1;
    @(posedge clk);
    #1;
    iv8 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_ov", int'(ov8), 0);
    chk("midrst_y", int'(y8), 0);
    chk("midrst_f", int'(fl8), 0);
    chk("midrst_rdy", int'(rdy8), 1);
    @(negedge clk);
    rst = 1'b0;
    do_op(8, 0, 'h10, 'h22, 0, 0, 0);

    for (int i = 0; i < 150; i++)
      do_op(8, int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 255)), int'($urandom_range(0, 1)),
            int'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
    for (int i = 0; i < 100; i++)
      do_op(16, int'($urandom_range(0, 7)), int'($urandom_range(0, 65535)),
            int'($urandom_range(0, 65535)), int'($urandom_range(0, 1)),
            int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the combinational 6502 ALU.
- Full op set: binary and nibble-serial BCD add/subtract, logic ops, and shift/rotate through carry.
- Result and flags are registered and held until the consumer accepts them.
- Sits between the decode/execute sequencer and the register file/status register.

Parameters:
- WIDTH, 8: operand and result width; must be a multiple of 4 when BCD_EN=1.
- BCD_EN, 1: 1 enables decimal mode; 0 executes BCD requests as binary.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operation request valid.
- in_ready  out  1  ALU can accept a request (high only in IDLE).
- op  in  3  opcode: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SR=5, SL=6, PASS=7 (Y=A).
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- carry_in  in  1  carry in; for SUB, 1 = no borrow.
- bcd  in  1  decimal mode; affects ADD and SUB only.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- y  out  WIDTH  registered result.
- flags  out  4  {N,V,Z,C} at bit indices NEG=3, OVF=2, ZERO=1, CARRY=0.
- flag_we  out  4  per-flag write mask, same bit order; 1 = flag computed by this op.

Behaviour:
- Reset: state=IDLE; y=0, flags=0, flag_we=0, out_valid=0. in_ready=1 the cycle after rst deasserts. Reset mid-operation abandons the op with no output.
- FSM states:
  - IDLE: in_ready=1. Accept on in_valid&in_ready and latch a, b, op, carry_in, bcd.
    - Binary ops go to DONE.
    - ADD/SUB with bcd&BCD_EN go to DEC with nibble index k=0.
  - DEC: one BCD digit per cycle, LSB digit first, carry/borrow propagated in a register. After k=WIDTH/4-1, go to DONE.
  - DONE: out_valid=1, y/flags/flag_we stable. On out_ready, go to IDLE. A new request cannot be accepted in the same cycle.
- Latency, with the accept edge as cycle 0:
  - Binary: out_valid at cycle 1.
  - BCD: out_valid at cycle 1+WIDTH/4 (cycle 3 for WIDTH=8).
- Binary arithmetic:
  - ADD: {C,y} = A+B+carry_in, computed at WIDTH+1 bits.
  - SUB: {C,y} = A+~B+carry_in.
  - V = signed overflow (operand MSBs equal, result MSB different).
- BCD add, per digit: s = a_d+b_d+c. If s>9 then s=s+6 and c=1, else c=0. Digit = s[3:0].
- BCD subtract, per digit: d = a_d-b_d-(~c). If d<0 then d=d-6 and borrow, so c=0; else c=1. Digit = d[3:0].
- BCD flags: C = final digit carry. V = binary-overflow of the same operands, computed at accept. N and Z come from the final adjusted y.
- Non-decimal digits (>9) give defined, deterministic per-digit output. The FSM never stalls.
- Logic ops (AND/OR/XOR/PASS): N=y[MSB], Z=(y==0). flag_we=4'b1010; C and V are driven 0 and must be ignored.
- SR: y={carry_in, A[W-1:1]}, C=A[0].
- SL: y={A[W-2:0], carry_in}, C=A[W-1].
- SR/SL: flag_we=4'b1011 (V not written).
- ADD/SUB: flag_we=4'b1111.
- Backpressure: while DONE and !out_ready, all outputs hold. in_ready=0 in DEC and DONE.

Decomposition:
- Package alu_pkg holds:
  - opcode constants;
  - flag bit indices NEG/OVF/ZERO/CARRY;
  - FSM state encodings IDLE/DEC/DONE.
- Shared with the decoder and the status register.
- One sub-module: bcd_digit (4-bit a, b, carry_in, sub → 4-bit digit, carry_out), combinational, instantiated once and time-multiplexed by the DEC state.

Test Plan:
- Binary ADD a=0x7F, b=0x01, cin=0 → cycle 1: y=0x80, flags N=1 V=1 Z=0 C=0, flag_we=0xF.
- Binary SUB a=0x00, b=0x01, cin=1 → y=0xFF, C=0, N=1, Z=0, V=0.
- BCD ADD a=0x58, b=0x46, cin=1 → out_valid exactly at cycle 3: y=0x05, C=1, Z=0. BCD SUB a=0x12, b=0x21, cin=1 → y=0x91, C=0, N=1.
- AND a=0xF0, b=0x0F → y=0x00, Z=1, N=0, flag_we=0xA. SR a=0x01, cin=1 → y=0x80, C=1, N=1, flag_we=0xB.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → y/flags stable and in_ready=0 throughout. out_ready=1 → IDLE next cycle. A back-to-back request is then accepted.
- Reset asserted during DEC (cycle 2 of a BCD ADD) → next cycle out_valid=0, y=0, flags=0, in_ready=1. A new binary ADD then completes normally. Repeat with WIDTH=16 and BCD ADD 0x9999+0x0001 → y=0x0000, C=1, Z=1 at cycle 5.
